// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU datapath sequencer: FSM states and opcode encoding.
package alu_seq_pkg;

   localparam int unsigned OPW = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_A = 2'd1,
      EXEC   = 2'd2,
      DRIVE  = 2'd3
   } state_t;

   typedef enum logic [OPW-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_PASS = 3'b111
   } op_t;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational ALU: result and carry/borrow for one opcode over N-bit operands.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int unsigned N = 10
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  op_t          op,
   output logic [N-1:0] result,
   output logic         carry
);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD:  {carry, result} = (N+1)'(a) + (N+1)'(b);
         OP_SUB: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL: begin
            result = {a[N-2:0], 1'b0};
            carry  = a[N-1];
         end
         OP_SHR: begin
            result = {1'b0, a[N-1:1]};
            carry  = a[0];
         end
         OP_PASS: result = b;
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_datapath.sv
// ALU datapath sequencer: captures operand A, computes into G, then drives G onto the bus.
module alu_seq_datapath
   import alu_seq_pkg::*;
#(
   parameter int unsigned N = 10
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [N-1:0]   BUS_IN,
   input  logic           start,
   input  logic [OPW-1:0] op,
   input  logic           chain,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   G_out,
   output logic           G_oe,
   output logic           carry,
   output logic           zero
);

   state_t       state;
   state_t       state_nxt;
   op_t          op_q;
   logic [N-1:0] a_q;
   logic [N-1:0] g_q;
   logic [N-1:0] alu_res;
   logic         alu_carry;

   alu_seq_core #(.N(N)) u_core (
      .a      (a_q),
      .b      (BUS_IN),
      .op     (op_q),
      .result (alu_res),
      .carry  (alu_carry)
   );

   // Status outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         G_oe  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DRIVE);
         G_oe  <= (state_nxt == DRIVE);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = chain ? EXEC : LOAD_A;
         LOAD_A:  state_nxt = EXEC;
         EXEC:    state_nxt = DRIVE;
         DRIVE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, result and flag update; G and flags change only in EXEC.
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q   <= '0;
         g_q   <= '0;
         op_q  <= OP_ADD;
         carry <= 1'b0;
         zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q <= op_t'(op);
                  if (chain) a_q <= g_q;
               end
            end
            LOAD_A: a_q <= BUS_IN;
            EXEC: begin
               g_q   <= alu_res;
               carry <= alu_carry;
               zero  <= (alu_res == '0);
            end
            default: ;
         endcase
      end
   end

   assign G_out = g_q;

endmodule

// File: tb/tb_alu_seq_datapath.sv
// Scoreboard bench: drives N=10 and N=16 sequencers with identical random traffic.
module tb_alu_seq_datapath;

   typedef struct {
      int unsigned issue;
      int unsigned due;
      logic [15:0] g;
      logic        c;
      logic        z;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] bus;
   logic        start;
   logic [2:0]  op;
   logic        chain;

   logic        busy10, done10, oe10, c10, z10;
   logic [9:0]  g10;
   logic        busy16, done16, oe16, c16, z16;
   logic [15:0] g16;

   exp_t        q10[$];
   exp_t        q16[$];
   logic [15:0] m_g10, m_g16;
   int unsigned cyc = 0;
   int          checks = 0;
   int          fails = 0;
   bit          aborting = 1'b0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   alu_seq_datapath #(.N(10)) dut10 (
      .CLK(CLK), .RST(RST), .BUS_IN(bus[9:0]), .start(start), .op(op), .chain(chain),
      .busy(busy10), .done(done10), .G_out(g10), .G_oe(oe10), .carry(c10), .zero(z10)
   );

   alu_seq_datapath #(.N(16)) dut16 (
      .CLK(CLK), .RST(RST), .BUS_IN(bus), .start(start), .op(op), .chain(chain),
      .busy(busy16), .done(done16), .G_out(g16), .G_oe(oe16), .carry(c16), .zero(z16)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference behaviour: plain unsigned arithmetic modulo 2^n.
   function automatic void model(input int n, input logic [2:0] o, input logic [15:0] a,
                                 input logic [15:0] b, output logic [15:0] g, output logic c);
      int unsigned m, av, bv, r;
      m  = (32'd1 << n) - 1;
      av = a & m;
      bv = b & m;
      r  = 0;
      c  = 1'b0;
      case (o)
         3'd0: begin r = av + bv; c = (r > m); end
         3'd1: begin r = av - bv; c = (av < bv); end
         3'd2: r = av & bv;
         3'd3: r = av | bv;
         3'd4: r = av ^ bv;
         3'd5: begin r = av * 2; c = ((av >> (n - 1)) & 1) != 0; end
         3'd6: begin r = av / 2; c = (av % 2) != 0; end
         default: r = bv;
      endcase
      g = 16'(r & m);
   endfunction

   task automatic mon(input string tag, inout exp_t q[$], input logic dn, input logic oe,
                      input logic bsy, input logic [15:0] g, input logic c, input logic z);
      bit   due;
      bit   exp_busy;
      exp_t e;
      due      = (q.size() > 0) && (q[0].due == cyc);
      exp_busy = (q.size() > 0) && (cyc > q[0].issue);
      check({tag, " done"}, 16'(dn), 16'(due));
      check({tag, " G_oe"}, 16'(oe), 16'(due));
      check({tag, " busy"}, 16'(bsy), 16'(exp_busy));
      if (due) begin
         e = q.pop_front();
         check({tag, " G"}, g, e.g);
         check({tag, " carry"}, 16'(c), 16'(e.c));
         check({tag, " zero"}, 16'(z), 16'(e.z));
      end
   endtask

   always @(negedge CLK) begin
      if (!RST && !aborting) begin
         mon("n10", q10, done10, oe10, busy10, 16'(g10), c10, z10);
         mon("n16", q16, done16, oe16, busy16, g16, c16, z16);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Random activity on the handshake inputs while the sequencer is busy.
   task automatic junk(input bit keep_bus);
      start = ($urandom_range(0, 3) != 0);
      op    = 3'($urandom);
      chain = 1'($urandom);
      if (!keep_bus) bus = 16'($urandom);
   endtask

   task automatic check_reset_state();
      check("rst n10 G", 16'(g10), 16'h0);
      check("rst n10 flags", {12'h0, busy10, done10, oe10, c10}, 16'h0);
      check("rst n10 zero", 16'(z10), 16'h0);
      check("rst n16 G", g16, 16'h0);
      check("rst n16 flags", {12'h0, busy16, done16, oe16, c16}, 16'h0);
      check("rst n16 zero", 16'(z16), 16'h0);
   endtask

   task automatic issue(input logic [2:0] o, input bit ch, input logic [15:0] av,
                        input logic [15:0] bv, input bit abort);
      logic [15:0] a, r;
      logic        c;
      aborting = abort;
      start = 1'b1;
      op    = o;
      chain = ch;
      bus   = 16'($urandom);
      if (!abort) begin
         a = ch ? m_g10 : av;
         model(10, o, a, bv, r, c);
         q10.push_back('{issue: cyc, due: cyc + (ch ? 2 : 3), g: r, c: c, z: (r == 16'h0)});
         m_g10 = r;
         a = ch ? m_g16 : av;
         model(16, o, a, bv, r, c);
         q16.push_back('{issue: cyc, due: cyc + (ch ? 2 : 3), g: r, c: c, z: (r == 16'h0)});
         m_g16 = r;
      end
      step();
      junk(1'b0);
      if (!ch) begin
         bus = av;
         step();
         junk(1'b1);
      end
      if (abort) begin
         RST   = 1'b1;
         start = 1'b0;
         step();
         step();
         RST = 1'b0;
         check_reset_state();
         m_g10 = 16'h0;
         m_g16 = 16'h0;
         aborting = 1'b0;
         return;
      end
      bus = bv;
      step();
      junk(1'b0);
      step();
      if ($urandom_range(0, 3) == 0) begin
         start = 1'b0;
         repeat ($urandom_range(1, 3)) step();
      end
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h0001;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      RST   = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      chain = 1'b0;
      bus   = 16'h0;
      m_g10 = 16'h0;
      m_g16 = 16'h0;
      repeat (3) step();
      RST = 1'b0;
      check_reset_state();

      issue(3'b000, 1'b0, 16'h03FF, 16'h0002, 1'b0);
      issue(3'b001, 1'b0, 16'h0005, 16'h0007, 1'b0);
      issue(3'b001, 1'b0, 16'h0007, 16'h0007, 1'b0);
      issue(3'b000, 1'b0, 16'h0008, 16'h0008, 1'b0);
      issue(3'b101, 1'b1, 16'h0000, 16'h0000, 1'b0);
      issue(3'b110, 1'b0, 16'h0201, 16'h0000, 1'b0);
      issue(3'b101, 1'b0, 16'h0200, 16'h0000, 1'b0);
      issue(3'b000, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
      issue(3'b111, 1'b0, 16'h0000, 16'h0155, 1'b0);
      issue(3'b000, 1'b0, 16'h0123, 16'h00FF, 1'b1);
      issue(3'b000, 1'b1, 16'h0000, 16'h0005, 1'b0);

      for (int i = 0; i < 150; i++) begin
         issue(3'($urandom), ($urandom_range(0, 2) == 0), pick(), pick(), 1'b0);
      end

      start = 1'b0;
      repeat (6) step();
      check("n10 drained", 16'(q10.size()), 16'h0);
      check("n16 drained", 16'(q16.size()), 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
